// File: rtl/svm_dot_array.sv
// Linear-kernel SVM scorer: a systolic chain of MAC lanes forms test.sv dot products,
// and a tail accumulator sums them per instance into a result bank.

module svm_mac_lane #(
   parameter int DATA_SIZE  = 32,
   parameter int ACCUM_SIZE = 64,
   parameter int K          = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  vld_in,
   input  logic                  first_in,
   input  logic                  last_in,
   input  logic [DATA_SIZE-1:0]  a_in,
   input  logic [DATA_SIZE-1:0]  b_in,
   input  logic [ACCUM_SIZE-1:0] acc_in,
   output logic                  vld_out,
   output logic                  first_out,
   output logic                  last_out,
   output logic [ACCUM_SIZE-1:0] acc_out
);
   logic [DATA_SIZE-1:0]  a_d, b_d;
   logic [ACCUM_SIZE-1:0] a_ext, b_ext, prod;

   // Feature K meets its partial sum K cycles after the pair is sampled, so it is skewed by K.
   if (K == 0) begin : g_direct
      assign a_d = a_in;
      assign b_d = b_in;
   end else begin : g_skew
      logic [K-1:0][DATA_SIZE-1:0] a_sr, b_sr;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
         end else begin
            a_sr[0] <= a_in;
            b_sr[0] <= b_in;
            for (int j = 1; j < K; j++) begin
               a_sr[j] <= a_sr[j-1];
               b_sr[j] <= b_sr[j-1];
            end
         end
      end
      assign a_d = a_sr[K-1];
      assign b_d = b_sr[K-1];
   end

   // Product modulo 2^ACCUM_SIZE of the sign-extended operands equals the signed product.
   assign a_ext = {{(ACCUM_SIZE-DATA_SIZE){a_d[DATA_SIZE-1]}}, a_d};
   assign b_ext = {{(ACCUM_SIZE-DATA_SIZE){b_d[DATA_SIZE-1]}}, b_d};
   assign prod  = a_ext * b_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_out   <= 1'b0;
         first_out <= 1'b0;
         last_out  <= 1'b0;
         acc_out   <= '0;
      end else begin
         vld_out   <= vld_in & ~clear;
         first_out <= first_in;
         last_out  <= last_in;
         acc_out   <= acc_in + prod;
      end
   end
endmodule

module svm_dot_array #(
   parameter int DATA_SIZE  = 32,
   parameter int ACCUM_SIZE = 64,
   parameter int NUM_FEAT   = 2,
   parameter int NUM_SV     = 3,
   parameter int NUM_INST   = 2,
   localparam int IDX_W     = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           in_valid,
   input  logic                           sv_first,
   input  logic                           sv_last,
   input  logic [NUM_FEAT*DATA_SIZE-1:0]  test_vec,
   input  logic [NUM_FEAT*DATA_SIZE-1:0]  sv_vec,
   output logic                           result_valid,
   output logic [IDX_W-1:0]               result_idx,
   output logic [ACCUM_SIZE-1:0]          result,
   output logic [NUM_INST*ACCUM_SIZE-1:0] results,
   output logic                           done
);
   logic [NUM_FEAT:0]                     vld_pipe, first_pipe, last_pipe;
   logic [ACCUM_SIZE-1:0]                 acc_pipe [0:NUM_FEAT];
   logic [ACCUM_SIZE-1:0]                 sum_q, sum_nxt;
   logic [IDX_W-1:0]                      idx_q;
   logic                                  idx_wrap;
   logic [NUM_INST-1:0][ACCUM_SIZE-1:0]   bank_q;

   assign vld_pipe[0]   = in_valid;
   assign first_pipe[0] = sv_first;
   assign last_pipe[0]  = sv_last;
   assign acc_pipe[0]   = '0;

   for (genvar k = 0; k < NUM_FEAT; k++) begin : g_lane
      svm_mac_lane #(.DATA_SIZE(DATA_SIZE), .ACCUM_SIZE(ACCUM_SIZE), .K(k)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear),
         .vld_in    (vld_pipe[k]),
         .first_in  (first_pipe[k]),
         .last_in   (last_pipe[k]),
         .a_in      (test_vec[k*DATA_SIZE +: DATA_SIZE]),
         .b_in      (sv_vec[k*DATA_SIZE +: DATA_SIZE]),
         .acc_in    (acc_pipe[k]),
         .vld_out   (vld_pipe[k+1]),
         .first_out (first_pipe[k+1]),
         .last_out  (last_pipe[k+1]),
         .acc_out   (acc_pipe[k+1])
      );
   end

   assign sum_nxt  = first_pipe[NUM_FEAT] ? acc_pipe[NUM_FEAT] : sum_q + acc_pipe[NUM_FEAT];
   assign idx_wrap = (idx_q == IDX_W'(NUM_INST-1));

   // clear restarts the batch but keeps previously filed scores in the bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q        <= '0;
         idx_q        <= '0;
         bank_q       <= '0;
         result       <= '0;
         result_idx   <= '0;
         result_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         done         <= 1'b0;
         if (clear) begin
            sum_q <= '0;
            idx_q <= '0;
         end else if (vld_pipe[NUM_FEAT]) begin
            sum_q <= sum_nxt;
            if (last_pipe[NUM_FEAT]) begin
               bank_q[idx_q] <= sum_nxt;
               result        <= sum_nxt;
               result_idx    <= idx_q;
               result_valid  <= 1'b1;
               done          <= idx_wrap;
               idx_q         <= idx_wrap ? '0 : idx_q + IDX_W'(1);
            end
         end
      end
   end

   assign results = bank_q;
endmodule

// File: tb/tb_svm_dot_array.sv
// Self-checking bench for svm_dot_array: directed scenarios plus random traffic
// compared against a pair-level scoring model.

module tb_svm_dot_array;
   localparam int DS = 32;
   localparam int AS = 64;
   localparam int NF = 2;
   localparam int NS = 3;
   localparam int NI = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic             sv_first = 1'b0;
   logic             sv_last = 1'b0;
   logic [NF*DS-1:0] test_vec = '0;
   logic [NF*DS-1:0] sv_vec = '0;
   logic             result_valid;
   logic [0:0]       result_idx;
   logic [AS-1:0]    result;
   logic [NI*AS-1:0] results;
   logic             done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   svm_dot_array #(.DATA_SIZE(DS), .ACCUM_SIZE(AS), .NUM_FEAT(NF), .NUM_SV(NS), .NUM_INST(NI)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .in_valid     (in_valid),
      .sv_first     (sv_first),
      .sv_last      (sv_last),
      .test_vec     (test_vec),
      .sv_vec       (sv_vec),
      .result_valid (result_valid),
      .result_idx   (result_idx),
      .result       (result),
      .results      (results),
      .done         (done)
   );

   // Reference model: each sampled pair carries its dot product and is scored NF edges later.
   typedef struct {
      int            due;
      bit            f;
      bit            l;
      logic [AS-1:0] dot;
   } pend_t;

   pend_t         pq[$];
   logic [AS-1:0] m_sum, m_res;
   logic [AS-1:0] m_bank [NI];
   int            m_idx, m_ridx, cyc;
   bit            m_rv, m_done;

   function automatic logic [NF*DS-1:0] vec2(input int f0, input int f1);
      return {f1, f0};
   endfunction

   function automatic logic [AS-1:0] dotp(input logic [NF*DS-1:0] a, input logic [NF*DS-1:0] b);
      longint s = 0;
      int     x, y;
      for (int k = 0; k < NF; k++) begin
         x = a[k*DS +: DS];
         y = b[k*DS +: DS];
         s += longint'(x) * longint'(y);
      end
      return s;
   endfunction

   function automatic logic [NI*AS-1:0] model_bank();
      logic [NI*AS-1:0] r;
      for (int i = 0; i < NI; i++) r[i*AS +: AS] = m_bank[i];
      return r;
   endfunction

   function automatic int rnd_feat();
      if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 20)) - 10;
      return int'($urandom);
   endfunction

   task automatic step(input bit v, input bit f, input bit l,
                       input logic [NF*DS-1:0] tv, input logic [NF*DS-1:0] sv, input bit clr);
      pend_t p;
      logic [AS-1:0] nxt;
      in_valid = v; sv_first = f; sv_last = l; test_vec = tv; sv_vec = sv; clear = clr;
      @(posedge clk);
      cyc++;
      m_rv = 0;
      m_done = 0;
      if (!rst_n) begin
         pq.delete();
         m_sum = '0; m_res = '0; m_idx = 0; m_ridx = 0;
         for (int i = 0; i < NI; i++) m_bank[i] = '0;
      end else if (clr) begin
         pq.delete();
         m_sum = '0;
         m_idx = 0;
      end else begin
         if (pq.size() != 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            nxt = p.f ? p.dot : m_sum + p.dot;
            m_sum = nxt;
            if (p.l) begin
               m_bank[m_idx] = nxt;
               m_res = nxt;
               m_ridx = m_idx;
               m_rv = 1;
               m_done = (m_idx == NI-1);
               m_idx = (m_idx == NI-1) ? 0 : m_idx + 1;
            end
         end
         if (v) begin
            p.due = cyc + NF; p.f = f; p.l = l; p.dot = dotp(tv, sv);
            pq.push_back(p);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, vec2(rnd_feat(), rnd_feat()), vec2(rnd_feat(), rnd_feat()), 0);
         checks++; if (results !== '0) begin errors++; $display("FAIL reset_results got %h exp 0", results); end
         checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", result_valid); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rv cyc %0d got %b exp 0", i, result_valid); end
      end
   endtask

   task automatic test_single();
      step(1, 1, 1, vec2(3, 4), vec2(5, 6), 0);
      idle();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", result_valid); end
      idle();
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_rv got %b exp 1", result_valid); end
      checks++; if (result !== 64'd39) begin errors++; $display("FAIL single_result got %0d exp 39", result); end
      checks++; if (result_idx !== 1'b0) begin errors++; $display("FAIL single_idx got %0d exp 0", result_idx); end
      checks++; if (results[0 +: AS] !== 64'd39) begin errors++; $display("FAIL single_bank0 got %0d exp 39", results[0 +: AS]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done got %b exp 0", done); end
   endtask

   task automatic test_instance();
      int n = 0, at = -1, gidx = -1;
      logic [AS-1:0] got = '0;
      bit gdone = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) step(1, i == 0, i == 2, vec2(1, 1), vec2(2*i+1, 2*i+2), 0);
         else idle();
         if (result_valid) begin n++; at = i; got = result; gidx = int'(result_idx); gdone = done; end
      end
      checks++; if (n != 1) begin errors++; $display("FAIL inst_count got %0d exp 1", n); end
      checks++; if (at != 4) begin errors++; $display("FAIL inst_latency got %0d exp 4", at); end
      checks++; if (got !== 64'd21) begin errors++; $display("FAIL inst_result got %0d exp 21", got); end
      checks++; if (gidx != 1) begin errors++; $display("FAIL inst_idx got %0d exp 1", gidx); end
      checks++; if (gdone !== 1'b1) begin errors++; $display("FAIL inst_done got %b exp 1", gdone); end
   endtask

   task automatic test_signed();
      logic [AS-1:0] exp_v [3];
      exp_v[0] = 64'hFFFF_FFFF_FFFF_FFE9;
      exp_v[1] = 64'h7FFF_FFFE_0000_0002;
      exp_v[2] = 64'h8000_0000_0000_0000;
      step(1, 1, 1, vec2(-2, 3), vec2(4, -5), 0);
      step(1, 1, 1, vec2(32'h7FFF_FFFF, 32'h7FFF_FFFF), vec2(32'h7FFF_FFFF, 32'h7FFF_FFFF), 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) step(1, 1, 1, vec2(32'h8000_0000, 32'h8000_0000), vec2(32'h8000_0000, 32'h8000_0000), 0);
         else idle();
         checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL signed_rv%0d got %b exp 1", i, result_valid); end
         checks++; if (result !== exp_v[i]) begin errors++; $display("FAIL signed_result%0d got %h exp %h", i, result, exp_v[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [AS-1:0] ev_v[$];
      int            ev_i[$];
      bit            ev_d[$];
      int            tv0[3] = '{1, 2, 1};
      int            tv1[3] = '{1, 2, 0};
      step(1, 1, 1, vec2(7, 7), vec2(7, 7), 1);
      for (int i = 0; i < 14; i++) begin
         int inst = (i < 3) ? 0 : (i < 4) ? -1 : (i < 7) ? 1 : (i < 10) ? 2 : -1;
         int sub  = (i < 3) ? i : (i < 4) ? 0 : (i < 7) ? i - 4 : i - 7;
         if (inst >= 0) step(1, sub == 0, sub == 2, vec2(tv0[inst], tv1[inst]), vec2(2*sub+1, 2*sub+2), 0);
         else idle();
         if (result_valid) begin ev_v.push_back(result); ev_i.push_back(int'(result_idx)); ev_d.push_back(done); end
      end
      checks++; if (ev_v.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", ev_v.size()); end
      if (ev_v.size() == 3) begin
         checks++; if (ev_v[0] !== 64'd21 || ev_i[0] != 0 || ev_d[0] !== 1'b0) begin errors++; $display("FAIL b2b_ev0 got %0d/%0d/%b exp 21/0/0", ev_v[0], ev_i[0], ev_d[0]); end
         checks++; if (ev_v[1] !== 64'd42 || ev_i[1] != 1 || ev_d[1] !== 1'b1) begin errors++; $display("FAIL b2b_ev1 got %0d/%0d/%b exp 42/1/1", ev_v[1], ev_i[1], ev_d[1]); end
         checks++; if (ev_v[2] !== 64'd9 || ev_i[2] != 0 || ev_d[2] !== 1'b0) begin errors++; $display("FAIL b2b_ev2 got %0d/%0d/%b exp 9/0/0", ev_v[2], ev_i[2], ev_d[2]); end
      end
      checks++; if (results !== {64'd42, 64'd9}) begin errors++; $display("FAIL b2b_bank got %h exp %h", results, {64'd42, 64'd9}); end
   endtask

   task automatic test_clear_reset();
      int n = 0;
      logic [AS-1:0] got = '0;
      int gidx = -1;
      step(1, 1, 0, vec2(1, 1), vec2(1, 2), 0);
      step(1, 0, 0, vec2(1, 1), vec2(3, 4), 0);
      step(1, 0, 1, vec2(1, 1), vec2(5, 6), 1);
      checks++; if (results !== {64'd42, 64'd9}) begin errors++; $display("FAIL clear_bank got %h exp %h", results, {64'd42, 64'd9}); end
      for (int i = 0; i < 4; i++) begin
         if (i == 0) step(1, 1, 1, vec2(2, 0), vec2(7, 9), 0);
         else idle();
         if (result_valid) begin n++; got = result; gidx = int'(result_idx); end
      end
      checks++; if (n != 1 || got !== 64'd14 || gidx != 0) begin errors++; $display("FAIL clear_restart got n=%0d v=%0d idx=%0d exp n=1 v=14 idx=0", n, got, gidx); end
      step(1, 0, 1, vec2(1, 0), vec2(6, 0), 0);
      idle(); idle();
      checks++; if (result !== 64'd20 || result_idx !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL carry_sum got %0d/%0d/%b exp 20/1/1", result, result_idx, done); end
      step(1, 1, 0, vec2(3, 3), vec2(3, 3), 0);
      step(1, 0, 1, vec2(3, 3), vec2(3, 3), 0);
      rst_n = 1'b0;
      #1;
      checks++; if (results !== '0) begin errors++; $display("FAIL midreset_bank got %h exp 0", results); end
      step(0, 0, 0, '0, '0, 0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         idle();
         if (result_valid) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL midreset_stale got %0d exp 0", n); end
      checks++; if (results !== '0) begin errors++; $display("FAIL midreset_after got %h exp 0", results); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              vec2(rnd_feat(), rnd_feat()), vec2(rnd_feat(), rnd_feat()), $urandom_range(0, 49) == 0);
         checks++; if (result_valid !== m_rv) begin errors++; $display("FAIL rand_rv cyc %0d got %b exp %b", cyc, result_valid, m_rv); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done cyc %0d got %b exp %b", cyc, done, m_done); end
         if (m_rv) begin
            checks++; if (result !== m_res || result_idx !== 1'(m_ridx)) begin errors++; $display("FAIL rand_result cyc %0d got %h/%0d exp %h/%0d", cyc, result, result_idx, m_res, m_ridx); end
         end
         checks++; if (results !== model_bank()) begin errors++; $display("FAIL rand_bank cyc %0d got %h exp %h", cyc, results, model_bank()); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_instance();
      test_signed();
      test_back_to_back();
      test_clear_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/svm_dot_array.md
Name: svm_dot_array

Overview:
- Linear-kernel SVM scoring engine: a systolic chain of NUM_FEAT multiply-accumulate stages computes test·sv dot products; a result accumulator sums those over the support vectors of each test instance and files the per-instance score into a result bank.
- Sits between the SV/test-vector memories and their sequencer, which streams one (test vector, support vector) pair per cycle.

Parameters:
- DATA_SIZE, 32, width of each feature element (signed two's complement)
- ACCUM_SIZE, 64, width of products, partial sums and results (signed)
- NUM_FEAT, 2, features per vector = number of pipeline stages (>=1)
- NUM_SV, 3, support vectors per instance (informational; framing comes from sv_first/sv_last)
- NUM_INST, 2, entries in the result bank (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous batch restart
- in_valid  in  1  pair presented this cycle
- sv_first  in  1  pair is the first SV of an instance
- sv_last  in  1  pair is the last SV of an instance
- test_vec  in  NUM_FEAT*DATA_SIZE  test vector; feature k at bits [k*DATA_SIZE +: DATA_SIZE]
- sv_vec  in  NUM_FEAT*DATA_SIZE  support vector, same packing
- result_valid  out  1  one-cycle pulse: instance score written
- result_idx  out  clog2(NUM_INST) (min 1)  bank index just written
- result  out  ACCUM_SIZE  score just written
- results  out  NUM_INST*ACCUM_SIZE  result bank; entry i at [i*ACCUM_SIZE +: ACCUM_SIZE]
- done  out  1  one-cycle pulse with the write to entry NUM_INST-1

Behaviour:
- Reset (rst_n=0, async): all stage registers, valid/first/last flags, running sum, instance index, results bank, result, result_idx, result_valid and done = 0.
- No backpressure. Input sampled every cycle; in_valid=0 is a bubble that propagates through the pipeline.
- Stage k (0..NUM_FEAT-1) registers on each clk: vec, sv, valid, first, last from stage k-1 (stage 0: from inputs); acc_q <= acc_in + sext(vec[k]) * sext(sv[k]).
- acc_in = 0 for stage 0; otherwise acc_q of stage k-1.
- The product is signed DATA_SIZE x DATA_SIZE, sign-extended to ACCUM_SIZE; addition wraps mod 2^ACCUM_SIZE.
- Dot product of a pair is valid at stage NUM_FEAT-1 exactly NUM_FEAT cycles after the pair is sampled.
- Accumulator acts on a valid pipe output dot:
  - next = first ? dot : sum + dot; sum <= next.
  - If last: results[idx] <= next, result <= next, result_idx <= idx, result_valid <= 1 (next cycle only).
  - Also on last: idx <= (idx == NUM_INST-1) ? 0 : idx+1; done <= (idx == NUM_INST-1).
- Total latency: sv_last sampled at cycle T -> result_valid high in cycle T+NUM_FEAT+1.
- The bank holds entries until overwritten, clear or reset; output is a flat register, valid the same cycle as result_valid.
- first and last on the same pair (NUM_SV=1): score = that single dot.
- last without a preceding first: adds to the carried-over sum (no error flag).
- first on a non-valid cycle: ignored.
- clear (sync, priority over the pipeline advance):
  - zeroes stage valid flags, sum, idx, result_valid and done;
  - preserves the results bank;
  - inputs sampled in the clear cycle are dropped.
- Reset mid-operation: all in-flight pairs discarded; the bank reads 0.

Test Plan:
- Reset with nonzero inputs and in_valid=1 -> results=0, result_valid=0, done=0 throughout reset; nothing emerges for 3 cycles after release with in_valid=0.
- Single pair test=(3,4), sv=(5,6), first=last=1 at cycle T -> result_valid at T+3, result=39, result_idx=0, results[0]=39, done=0.
- Instance with test=(1,1) against SVs (1,2),(3,4),(5,6) on consecutive cycles (first on 1st, last on 3rd) -> single result_valid, result=21 (3+7+11).
- Signed: test=(-2,3), sv=(4,-5), first=last -> result=0xFFFFFFFFFFFFFFE9 (-23); test=(0x7FFFFFFF,0x7FFFFFFF), sv same -> 0x7FFFFFFE00000002.
- Two instances back-to-back (3 SVs each, scores 21 then 42), interleaved with one bubble -> results[0]=21, results[1]=42; done pulses with the second write; the third instance writes results[0] (index wraps).
- Mid-instance clear, then rst_n pulse -> after clear the next instance restarts at index 0 and the bank is unchanged; after reset the bank is all zero and no stale result_valid appears.
